qsfp_snapshot: RTL and testbench

- Sits directly downstream of the Marble QSFP readout wrapper, on its bus side.
- On each new I2C pass, it freezes the wrapper's result buffer and walks every byte offset of every QSFP through the wrapper's 8-bit read port. It packs the bytes into 16-bit words in a local shadow RAM, then releases freeze.
- Processor GPIO reads are served from the shadow RAM using the existing word index: qidx = (qsfp*256 + offset) >> 1, with [15:8] = even byte and [7:0] = odd byte. Software therefore never waits on the I2C engine.

---
 rtl/qsfp_snapshot.sv | 173 +++++++++++++++++
 tb/tb_qsfp_snapshot.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qsfp_snapshot.sv
// Shadow copy of the QSFP readout buffer: on each new I2C pass the wrapper is frozen,
// walked byte by byte, packed into 16-bit words, and served to the processor from local RAM.
module qsfp_snapshot #(
   parameter int QSFP_COUNT    = 2,
   parameter int READ_LATENCY  = 1,
   parameter int FREEZE_SETTLE = 4,
   parameter int STALE_CYCLES  = 200000000,
   localparam int QW = $clog2(QSFP_COUNT)
) (
   input  logic          clk,
   input  logic          rstn,
   output logic [QW+7:0] qsfpReadAddress,
   input  logic [7:0]    qsfpReadData,
   output logic          freeze,
   input  logic          run_stat,
   input  logic          updated,
   input  logic [QW+6:0] sysReadAddress,
   output logic [15:0]   sysReadData,
   output logic          dataValid,
   output logic          busy,
   output logic [15:0]   snapshotCount
);

   localparam int BW = QW + 8;
   localparam int NW = QSFP_COUNT * 128;
   localparam int SW = (STALE_CYCLES > 1) ? $clog2(STALE_CYCLES + 1) : 1;
   localparam logic [BW-1:0] LAST_B     = BW'(QSFP_COUNT * 256 - 1);
   localparam logic [15:0]   SETTLE_END = 16'((FREEZE_SETTLE > 0) ? FREEZE_SETTLE - 1 : 0);
   localparam logic [2:0]    WAIT_END   = 3'((READ_LATENCY > 0) ? READ_LATENCY - 1 : 0);
   localparam logic [SW-1:0] STALE_MAX  = SW'(STALE_CYCLES);
   localparam logic [SW-1:0] STALE_TRIP = SW'((STALE_CYCLES > 0) ? STALE_CYCLES - 1 : 0);

   typedef enum logic [2:0] {IDLE, FREEZE, ADDR, WAIT, STORE, DONE} state_t;

   state_t          state_reg;
   logic            updated_d_reg;
   logic            pending_reg;
   logic [15:0]     settle_reg;
   logic [2:0]      wait_reg;
   logic [BW-1:0]   b_reg;
   logic [BW-1:0]   addr_reg;
   logic [7:0]      hi_reg;
   logic            wr_en_reg;
   logic [BW-2:0]   wr_idx_reg;
   logic [15:0]     wr_data_reg;
   logic            freeze_reg;
   logic            busy_reg;
   logic            valid_reg;
   logic [15:0]     count_reg;
   logic [SW-1:0]   stale_reg;
   logic [15:0]     rd_reg;
   logic [15:0]     shadow_mem [NW];

   logic trig;
   logic capture;

   assign trig = updated & ~updated_d_reg & run_stat;
   // STORE doubles as the address cycle of the next byte, so it may capture too when latency is zero.
   assign capture = (((state_reg == ADDR) || (state_reg == STORE)) && (READ_LATENCY == 0)) ||
                    ((state_reg == WAIT) && (wait_reg == WAIT_END));

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_reg     <= IDLE;
         updated_d_reg <= 1'b0;
         pending_reg   <= 1'b0;
         settle_reg    <= '0;
         wait_reg      <= '0;
         b_reg         <= '0;
         addr_reg      <= '0;
         hi_reg        <= '0;
         wr_en_reg     <= 1'b0;
         wr_idx_reg    <= '0;
         wr_data_reg   <= '0;
         freeze_reg    <= 1'b0;
         busy_reg      <= 1'b0;
         valid_reg     <= 1'b0;
         count_reg     <= '0;
         stale_reg     <= '0;
      end else begin
         updated_d_reg <= updated;
         wr_en_reg     <= 1'b0;
         if (trig && (state_reg != IDLE))
            pending_reg <= 1'b1;

         if (state_reg == DONE) begin
            stale_reg <= '0;
         end else if (STALE_CYCLES != 0) begin
            if (stale_reg != STALE_MAX)
               stale_reg <= stale_reg + 1'b1;
            if (stale_reg >= STALE_TRIP)
               valid_reg <= 1'b0;
         end

         case (state_reg)
            IDLE: begin
               if (trig || pending_reg) begin
                  pending_reg <= 1'b0;
                  freeze_reg  <= 1'b1;
                  busy_reg    <= 1'b1;
                  settle_reg  <= '0;
                  state_reg   <= FREEZE;
               end
            end
            FREEZE: begin
               if (settle_reg == SETTLE_END) begin
                  b_reg     <= '0;
                  addr_reg  <= '0;
                  state_reg <= ADDR;
               end else begin
                  settle_reg <= settle_reg + 16'd1;
               end
            end
            ADDR, STORE: begin
               if (READ_LATENCY != 0) begin
                  wait_reg  <= '0;
                  state_reg <= WAIT;
               end
            end
            WAIT: begin
               if (!capture)
                  wait_reg <= wait_reg + 3'd1;
            end
            DONE: begin
               freeze_reg <= 1'b0;
               count_reg  <= count_reg + 16'd1;
               valid_reg  <= 1'b1;
               state_reg  <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase

         // Odd bytes complete a word; the RAM write lands one cycle later, during STORE or DONE.
         if (capture) begin
            if (!b_reg[0]) begin
               hi_reg <= qsfpReadData;
            end else begin
               wr_en_reg   <= 1'b1;
               wr_idx_reg  <= b_reg[BW-1:1];
               wr_data_reg <= {hi_reg, qsfpReadData};
            end
            if (b_reg == LAST_B) begin
               busy_reg  <= 1'b0;
               state_reg <= DONE;
            end else begin
               b_reg     <= b_reg + 1'b1;
               addr_reg  <= b_reg + 1'b1;
               state_reg <= STORE;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en_reg)
         shadow_mem[wr_idx_reg] <= wr_data_reg;
   end

   always_ff @(posedge clk) begin
      if (!rstn || !valid_reg)
         rd_reg <= '0;
      else
         rd_reg <= shadow_mem[sysReadAddress];
   end

   assign qsfpReadAddress = addr_reg;
   assign freeze          = freeze_reg;
   assign busy            = busy_reg;
   assign dataValid       = valid_reg;
   assign snapshotCount   = count_reg;
   assign sysReadData     = rd_reg;

endmodule

// File: tb/tb_qsfp_snapshot.sv
// Scoreboard bench for qsfp_snapshot: three instances (defaults, READ_LATENCY=3, STALE_CYCLES=50)
// each fed by a wrapper model returning byte = offset ^ (qsfp<<7).
`timescale 1ns/1ps
module tb_qsfp_snapshot;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [2:0]  rstn_v;
   logic [2:0]  upd_v;
   logic [2:0]  run_v;
   logic [7:0]  sys_addr;
   logic [8:0]  qaddr [3];
   logic [15:0] sdata [3];
   logic        frz [3];
   logic        dv [3];
   logic        bsy [3];
   logic [15:0] cnt [3];
   logic [7:0]  qdata_a, qdata_c;
   logic [8:0]  b_p1, b_p2, b_p3;
   logic [7:0]  qdata_b;

   int n_vec = 0;
   int n_err = 0;

   function automatic logic [7:0] wrap_byte(input logic [8:0] a);
      return a[7:0] ^ {a[8], 7'b0};
   endfunction

   always @(posedge clk) begin
      qdata_a <= wrap_byte(qaddr[0]);
      qdata_c <= wrap_byte(qaddr[2]);
      b_p1    <= qaddr[1];
      b_p2    <= b_p1;
      b_p3    <= b_p2;
   end
   assign qdata_b = wrap_byte(b_p3);

   qsfp_snapshot dut_a (
      .clk(clk), .rstn(rstn_v[0]), .qsfpReadAddress(qaddr[0]), .qsfpReadData(qdata_a),
      .freeze(frz[0]), .run_stat(run_v[0]), .updated(upd_v[0]), .sysReadAddress(sys_addr),
      .sysReadData(sdata[0]), .dataValid(dv[0]), .busy(bsy[0]), .snapshotCount(cnt[0]));

   qsfp_snapshot #(.READ_LATENCY(3)) dut_b (
      .clk(clk), .rstn(rstn_v[1]), .qsfpReadAddress(qaddr[1]), .qsfpReadData(qdata_b),
      .freeze(frz[1]), .run_stat(run_v[1]), .updated(upd_v[1]), .sysReadAddress(sys_addr),
      .sysReadData(sdata[1]), .dataValid(dv[1]), .busy(bsy[1]), .snapshotCount(cnt[1]));

   qsfp_snapshot #(.STALE_CYCLES(50)) dut_c (
      .clk(clk), .rstn(rstn_v[2]), .qsfpReadAddress(qaddr[2]), .qsfpReadData(qdata_c),
      .freeze(frz[2]), .run_stat(run_v[2]), .updated(upd_v[2]), .sysReadAddress(sys_addr),
      .sysReadData(sdata[2]), .dataValid(dv[2]), .busy(bsy[2]), .snapshotCount(cnt[2]));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end else begin
         $display("ok   %s: 0x%0h", name, act);
      end
   endtask

   // Read scoreboard: issue pushes the expected word, monitor pops one cycle later.
   typedef struct {int sel; logic [7:0] addr; logic [15:0] exp;} rd_t;
   rd_t  rd_q [$];
   logic rd_v = 1'b0;
   logic rd_v_d = 1'b0;

   task automatic rd(input int sel, input logic [7:0] a, input logic [15:0] e);
      rd_t t;
      t.sel = sel; t.addr = a; t.exp = e;
      @(posedge clk); #1;
      sys_addr = a;
      rd_v = 1'b1;
      rd_q.push_back(t);
      @(posedge clk); #1;
      rd_v = 1'b0;
   endtask

   always @(posedge clk) rd_v_d <= rd_v;

   always @(negedge clk) begin : rd_mon
      rd_t e;
      if (rd_v_d) begin
         if (rd_q.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL read_unexpected: got 0x%0h, expected no read", sdata[0]);
         end else begin
            e = rd_q.pop_front();
            check($sformatf("read dut%0d qidx 0x%02h", e.sel, e.addr), {16'd0, sdata[e.sel]}, {16'd0, e.exp});
         end
      end
   end

   // Freeze-pulse scoreboard: each expected snapshot pushes its freeze-high length.
   typedef struct {int sel; int len;} fl_t;
   fl_t  fl_q [$];
   int   frz_len [3];
   logic frz_prev [3];

   task automatic expect_len(input int sel, input int len);
      fl_t t;
      t.sel = sel; t.len = len;
      fl_q.push_back(t);
   endtask

   always @(negedge clk) begin : frz_mon
      fl_t f;
      for (int i = 0; i < 3; i++) begin
         if (frz[i] === 1'b1) begin
            frz_len[i] = (frz_prev[i] === 1'b1) ? frz_len[i] + 1 : 1;
         end else if (frz_prev[i] === 1'b1) begin
            if (fl_q.size() == 0 || fl_q[0].sel != i) begin
               n_vec++; n_err++;
               $display("FAIL freeze_pulse dut%0d: got unexpected pulse of %0d cycles, required none", i, frz_len[i]);
            end else begin
               f = fl_q.pop_front();
               check($sformatf("freeze_len dut%0d", i), frz_len[i], f.len);
            end
         end
         frz_prev[i] = frz[i];
      end
   end

   int   dv_len_c = 0;
   logic dv_fell_c = 1'b0;
   logic dv_prev_c = 1'b0;
   always @(negedge clk) begin
      if (dv[2] === 1'b1)
         dv_len_c = (dv_prev_c === 1'b1) ? dv_len_c + 1 : 1;
      else if (dv_prev_c === 1'b1)
         dv_fell_c = 1'b1;
      dv_prev_c = dv[2];
   end

   task automatic pulse(input int sel);
      @(posedge clk); #1; upd_v[sel] = 1'b1;
      @(posedge clk); #1; upd_v[sel] = 1'b0;
   endtask

   task automatic wait_frz(input int sel, input logic val, input int max, input string name);
      int k = 0;
      while (frz[sel] !== val && k < max) begin
         @(negedge clk); k++;
      end
      if (frz[sel] !== val) begin
         n_vec++; n_err++;
         $display("FAIL %s: freeze=%b after %0d cycles, required %b", name, frz[sel], max, val);
      end
   endtask

   task automatic addr_run(input int sel, input logic [8:0] a, input int exp, input string name);
      int k = 0;
      int run = 0;
      while (qaddr[sel] !== a && k < 5000) begin
         @(negedge clk); k++;
      end
      while (qaddr[sel] === a && run < 100) begin
         @(negedge clk); run++;
      end
      check(name, run, exp);
   endtask

   task automatic watch_quiet(input int sel, input int n, input string name);
      logic seen = 1'b0;
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         if (frz[sel] !== 1'b0) seen = 1'b1;
      end
      check(name, {31'd0, seen}, 32'd0);
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation still running at 1ms, required completion");
      $fatal(1, "watchdog");
   end

   logic [7:0]  tab_a [8] = '{8'h00, 8'h7F, 8'h80, 8'hFF, 8'h01, 8'h40, 8'hC0, 8'h3F};
   logic [15:0] tab_e [8] = '{16'h0001, 16'hFEFF, 16'h8081, 16'h7E7F, 16'h0203, 16'h8081, 16'h0001, 16'h7E7F};

   initial begin
      int k;
      logic [7:0] q;
      rstn_v = 3'b000; upd_v = 3'b000; run_v = 3'b111; sys_addr = 8'h00;
      repeat (3) @(posedge clk);
      #1 rstn_v = 3'b111;

      // Reset then idle
      repeat (100) @(posedge clk);
      @(negedge clk);
      check("idle freeze", {31'd0, frz[0]}, 32'd0);
      check("idle busy", {31'd0, bsy[0]}, 32'd0);
      check("idle dataValid", {31'd0, dv[0]}, 32'd0);
      check("idle count", {16'd0, cnt[0]}, 32'd0);
      rd(0, 8'h00, 16'h0000);
      rd(0, 8'h80, 16'h0000);

      // Single snapshot, defaults
      expect_len(0, 1029);
      @(posedge clk); #1 upd_v[0] = 1'b1;
      @(negedge clk);
      check("freeze before edge seen", {31'd0, frz[0]}, 32'd0);
      @(posedge clk); #1;
      check("freeze rise", {31'd0, frz[0]}, 32'd1);
      check("busy rise", {31'd0, bsy[0]}, 32'd1);
      upd_v[0] = 1'b0;
      addr_run(0, 9'h005, 2, "dut0 addr hold");
      wait_frz(0, 1'b0, 1200, "dut0 snapshot end");
      check("count after 1", {16'd0, cnt[0]}, 32'd1);
      check("valid after 1", {31'd0, dv[0]}, 32'd1);
      check("busy after 1", {31'd0, bsy[0]}, 32'd0);
      for (int i = 0; i < 8; i++) rd(0, tab_a[i], tab_e[i]);

      // Events during busy coalesce into one follow-on snapshot
      @(posedge clk); #1 rstn_v[0] = 1'b0;
      @(posedge clk); #1 rstn_v[0] = 1'b1;
      check("rst count", {16'd0, cnt[0]}, 32'd0);
      check("rst valid", {31'd0, dv[0]}, 32'd0);
      rd(0, 8'h80, 16'h0000);
      expect_len(0, 1029);
      expect_len(0, 1029);
      pulse(0);
      repeat (298) @(posedge clk);
      pulse(0);
      repeat (198) @(posedge clk);
      pulse(0);
      wait_frz(0, 1'b0, 1200, "dut0 first of pair");
      k = 0;
      while (frz[0] !== 1'b1 && k < 20) begin
         @(negedge clk); k++;
      end
      check("follow-on gap", k, 1);
      wait_frz(0, 1'b0, 1200, "dut0 follow-on end");
      watch_quiet(0, 50, "no third snapshot");
      check("count after pair", {16'd0, cnt[0]}, 32'd2);

      // run_stat gating
      run_v[0] = 1'b0;
      pulse(0);
      watch_quiet(0, 50, "gated no snapshot");
      check("gated count", {16'd0, cnt[0]}, 32'd2);
      run_v[0] = 1'b1;

      // READ_LATENCY = 3
      expect_len(1, 2053);
      pulse(1);
      addr_run(1, 9'h001, 4, "dut1 addr1 hold");
      addr_run(1, 9'h101, 4, "dut1 addr101 hold");
      wait_frz(1, 1'b0, 2500, "dut1 snapshot end");
      check("dut1 count", {16'd0, cnt[1]}, 32'd1);
      check("dut1 valid", {31'd0, dv[1]}, 32'd1);
      for (int i = 0; i < 8; i++) rd(1, tab_a[i], tab_e[i]);
      for (int i = 0; i < 256; i++) begin
         q = 8'(i);
         rd(1, q, {wrap_byte({q, 1'b0}), wrap_byte({q, 1'b1})});
      end

      // Reset mid-snapshot, then stale timeout
      expect_len(2, 400);
      pulse(2);
      repeat (399) @(posedge clk);
      #1 rstn_v[2] = 1'b0;
      @(posedge clk); #1 rstn_v[2] = 1'b1;
      check("midrst freeze", {31'd0, frz[2]}, 32'd0);
      check("midrst busy", {31'd0, bsy[2]}, 32'd0);
      check("midrst valid", {31'd0, dv[2]}, 32'd0);
      check("midrst count", {16'd0, cnt[2]}, 32'd0);
      watch_quiet(2, 20, "midrst stays idle");
      rd(2, 8'h80, 16'h0000);
      dv_fell_c = 1'b0;
      expect_len(2, 1029);
      pulse(2);
      wait_frz(2, 1'b0, 1200, "dut2 snapshot end");
      rd(2, 8'h80, 16'h8081);
      rd(2, 8'h00, 16'h0001);
      k = 0;
      while (!dv_fell_c && k < 200) begin
         @(negedge clk); k++;
      end
      check("stale valid length", dv_len_c, 50);
      check("stale valid low", {31'd0, dv[2]}, 32'd0);
      check("stale count", {16'd0, cnt[2]}, 32'd1);
      rd(2, 8'h80, 16'h0000);

      repeat (5) @(posedge clk);
      check("reads outstanding", rd_q.size(), 0);
      check("snapshots outstanding", fl_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
